// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//    Three-state fetch unit: issues a one-cycle read to instruction memory,
//    captures the returned word, then holds it until the decoder accepts it.
//    A redirect (branch/jump) restarts fetching at a new word-aligned address
//    and discards whatever was in flight.
//
//    state   | meaning
//    --------+---------------------------------------------------------------
//    FETCH   | imem_rd high, address = pc_reg
//    CAPTURE | read data arriving this cycle, latched into instr/pc
//    HOLD    | instr_valid high, waiting for instr_ready
//
// Ports
//    clk, reset          clock, synchronous active-high reset
//    imem_addr/rd/rdata  instruction memory port (data one cycle after rd)
//    instr, pc           fetched word and its address
//    instr_valid/ready   handshake to the decoder
//    redirect(_target)   change of flow; target forced to word alignment
//    misalign_err        one-cycle pulse after a non-aligned redirect target
//    fetch_count         instructions accepted downstream (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC          = 32'h0000_0000,
   // fetch_count value after reset; nonzero only to exercise counter wrap
   parameter logic [31:0] FETCH_COUNT_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_rd,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   logic [31:0] pc_reg_q, pc_reg_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        misalign_err_q, misalign_err_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        rd_state;

   always_comb begin
      state_d        = state_q;
      pc_reg_d       = pc_reg_q;
      instr_d        = instr_q;
      pc_d           = pc_q;
      instr_valid_d  = instr_valid_q;
      fetch_count_d  = fetch_count_q;
      misalign_err_d = 1'b0;
      rd_state       = 1'b0;

      case (state_q)
         FETCH: begin
            rd_state = 1'b1;
            state_d  = CAPTURE;
         end
         CAPTURE: begin
            instr_d       = imem_rdata;
            pc_d          = pc_reg_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
         end
         HOLD: begin
            if (instr_ready && instr_valid_q) begin
               pc_reg_d      = pc_reg_q + 32'd4;
               fetch_count_d = fetch_count_q + 32'd1;
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end
         end
         default: begin
            state_d       = FETCH;
            instr_valid_d = 1'b0;
         end
      endcase

      // Redirect wins over everything above: no capture, no acceptance count.
      if (redirect) begin
         pc_reg_d       = {redirect_target[31:2], 2'b00};
         state_d        = FETCH;
         instr_d        = instr_q;
         pc_d           = pc_q;
         instr_valid_d  = 1'b0;
         fetch_count_d  = fetch_count_q;
         misalign_err_d = |redirect_target[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= FETCH;
         pc_reg_q       <= RESET_PC_ALIGNED;
         instr_q        <= 32'h0;
         pc_q           <= 32'h0;
         instr_valid_q  <= 1'b0;
         misalign_err_q <= 1'b0;
         fetch_count_q  <= FETCH_COUNT_RESET;
      end else begin
         state_q        <= state_d;
         pc_reg_q       <= pc_reg_d;
         instr_q        <= instr_d;
         pc_q           <= pc_d;
         instr_valid_q  <= instr_valid_d;
         misalign_err_q <= misalign_err_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

   // Read strobe is suppressed while reset is held so memory sees no access.
   assign imem_rd      = rd_state & ~reset;
   assign imem_addr    = pc_reg_q;
   assign instr        = instr_q;
   assign pc           = pc_q;
   assign instr_valid  = instr_valid_q;
   assign misalign_err = misalign_err_q;
   assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic        imem_rd;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        misalign_err;
   logic [31:0] fetch_count;

   logic        w_reset;
   logic [31:0] w_addr;
   logic        w_rd;
   logic [31:0] w_rdata;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic        w_valid;
   logic        w_ready;
   logic        w_redirect;
   logic [31:0] w_target;
   logic        w_misalign;
   logic [31:0] w_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instruction_fetch u_dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .imem_rdata(imem_rdata), .instr(instr), .pc(pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_target(redirect_target),
      .misalign_err(misalign_err), .fetch_count(fetch_count)
   );

   instruction_fetch #(
      .RESET_PC(32'hFFFF_FFFC), .FETCH_COUNT_RESET(32'hFFFF_FFFF)
   ) u_wrap (
      .clk(clk), .reset(w_reset), .imem_addr(w_addr), .imem_rd(w_rd),
      .imem_rdata(w_rdata), .instr(w_instr), .pc(w_pc), .instr_valid(w_valid),
      .instr_ready(w_ready), .redirect(w_redirect), .redirect_target(w_target),
      .misalign_err(w_misalign), .fetch_count(w_count)
   );

   // Memory: word at address A is A + 0x13; garbage when no read was issued.
   always @(posedge clk) begin
      imem_rdata <= imem_rd ? (imem_addr + 32'h13) : 32'hDEAD_BEEF;
      w_rdata    <= w_rd    ? (w_addr    + 32'h13) : 32'hDEAD_BEEF;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
      step(); step();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
      tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL rst_count: got %h want 0", fetch_count); end
      tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL rst_rd: got %b want 0", imem_rd); end
      tests++; if (imem_addr !== 32'h0 || pc !== 32'h0 || instr !== 32'h0) begin
         fails++; $display("FAIL rst_regs: addr %h pc %h instr %h want all 0", imem_addr, pc, instr); end
      tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", misalign_err); end
   endtask

   task automatic test_first_fetch();
      reset = 1'b0; instr_ready = 1'b1;
      #1;
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 32'h0) begin
         fails++; $display("FAIL c0_fetch: rd %b addr %h want 1 00000000", imem_rd, imem_addr); end
      step();
      tests++; if (imem_rd !== 1'b0 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL c1_capture: rd %b valid %b want 0 0", imem_rd, instr_valid); end
      step();
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h13 || pc !== 32'h0) begin
         fails++; $display("FAIL c2_valid: valid %b instr %h pc %h want 1 00000013 00000000", instr_valid, instr, pc); end
      step();
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0 || fetch_count !== 32'd1) begin
         fails++; $display("FAIL c3_next: rd %b addr %h valid %b cnt %0d want 1 00000004 0 1", imem_rd, imem_addr, instr_valid, fetch_count); end
   endtask

   task automatic test_hold_stall();
      instr_ready = 1'b0;
      step(); step();
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h17 || pc !== 32'h4) begin
         fails++; $display("FAIL stall_enter: valid %b instr %h pc %h want 1 00000017 00000004", instr_valid, instr, pc); end
      for (int i = 0; i < 5; i++) begin
         step();
         tests++; if (instr_valid !== 1'b1 || instr !== 32'h17 || pc !== 32'h4 || imem_rd !== 1'b0 || fetch_count !== 32'd1) begin
            fails++; $display("FAIL stall_hold%0d: valid %b instr %h pc %h rd %b cnt %0d want 1 00000017 00000004 0 1",
                              i, instr_valid, instr, pc, imem_rd, fetch_count); end
      end
      instr_ready = 1'b1;
      step();
      tests++; if (fetch_count !== 32'd2 || imem_addr !== 32'h8 || imem_rd !== 1'b1 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL stall_release: cnt %0d addr %h rd %b valid %b want 2 00000008 1 0", fetch_count, imem_addr, imem_rd, instr_valid); end
   endtask

   task automatic test_redirect_capture();
      instr_ready = 1'b0;
      step();
      redirect = 1'b1; redirect_target = 32'h100;
      step();
      redirect = 1'b0;
      tests++; if (imem_rd !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
         fails++; $display("FAIL rdc_fetch: rd %b addr %h valid %b mis %b want 1 00000100 0 0", imem_rd, imem_addr, instr_valid, misalign_err); end
      step();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rdc_stale: got valid %b want 0", instr_valid); end
      step();
      tests++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h113 || fetch_count !== 32'd2) begin
         fails++; $display("FAIL rdc_valid: valid %b pc %h instr %h cnt %0d want 1 00000100 00000113 2", instr_valid, pc, instr, fetch_count); end
   endtask

   task automatic test_redirect_vs_ready();
      instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
      step();
      redirect = 1'b0; instr_ready = 1'b0;
      tests++; if (fetch_count !== 32'd2 || imem_addr !== 32'h40 || imem_rd !== 1'b1 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL rvr_prio: cnt %0d addr %h rd %b valid %b want 2 00000040 1 0", fetch_count, imem_addr, imem_rd, instr_valid); end
      step(); step();
      tests++; if (instr_valid !== 1'b1 || pc !== 32'h40 || instr !== 32'h53) begin
         fails++; $display("FAIL rvr_valid: valid %b pc %h instr %h want 1 00000040 00000053", instr_valid, pc, instr); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      tests++; if (fetch_count !== 32'd3 || imem_addr !== 32'h44) begin
         fails++; $display("FAIL rvr_accept: cnt %0d addr %h want 3 00000044", fetch_count, imem_addr); end
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_target = 32'h102;
      step();
      redirect = 1'b0;
      tests++; if (misalign_err !== 1'b1 || imem_addr !== 32'h100 || imem_rd !== 1'b1) begin
         fails++; $display("FAIL mis_pulse: mis %b addr %h rd %b want 1 00000100 1", misalign_err, imem_addr, imem_rd); end
      step();
      tests++; if (misalign_err !== 1'b0 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL mis_clear: mis %b valid %b want 0 0", misalign_err, instr_valid); end
      step();
      tests++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h113) begin
         fails++; $display("FAIL mis_valid: valid %b pc %h instr %h want 1 00000100 00000113", instr_valid, pc, instr); end
   endtask

   task automatic test_reset_override();
      reset = 1'b1; redirect = 1'b1; redirect_target = 32'h80; instr_ready = 1'b1;
      step();
      tests++; if (instr_valid !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 32'h0 || imem_rd !== 1'b0 ||
                   pc !== 32'h0 || instr !== 32'h0 || misalign_err !== 1'b0) begin
         fails++; $display("FAIL rst_override: valid %b cnt %h addr %h rd %b pc %h instr %h mis %b want 0 0 0 0 0 0 0",
                           instr_valid, fetch_count, imem_addr, imem_rd, pc, instr, misalign_err); end
      reset = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
   endtask

   task automatic test_wrap();
      w_reset = 1'b1; w_ready = 1'b0;
      step();
      tests++; if (w_count !== 32'hFFFF_FFFF || w_addr !== 32'hFFFF_FFFC) begin
         fails++; $display("FAIL wrap_reset: cnt %h addr %h want ffffffff fffffffc", w_count, w_addr); end
      w_reset = 1'b0; w_ready = 1'b1;
      step(); step();
      tests++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_instr !== 32'h0000_000F) begin
         fails++; $display("FAIL wrap_hold: valid %b pc %h instr %h want 1 fffffffc 0000000f", w_valid, w_pc, w_instr); end
      step();
      tests++; if (w_addr !== 32'h0 || w_count !== 32'h0 || w_rd !== 1'b1) begin
         fails++; $display("FAIL wrap_next: addr %h cnt %h rd %b want 00000000 00000000 1", w_addr, w_count, w_rd); end
      w_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
      w_reset = 1'b1; w_ready = 1'b0; w_redirect = 1'b0; w_target = 32'h0;
      imem_rdata = 32'h0; w_rdata = 32'h0;
      test_reset();
      test_first_fetch();
      test_hold_stall();
      test_redirect_capture();
      test_redirect_vs_ready();
      test_misalign();
      test_reset_override();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
